// File: rtl/aes256_unload_pkg.sv
// Shared types and helpers for the AES-256 unload buffer.
// Block type, FSM state encoding and words-per-block helper.
package aes256_unload_pkg;

   localparam int AES_BLOCK_W = 128;

   typedef enum logic {
      ST_EMPTY,
      ST_ACTIVE
   } unload_state_t;

   typedef logic [127:0] aes_block_t;

   function automatic int words_per_block(input int out_w);
      return AES_BLOCK_W / out_w;
   endfunction

endpackage

// File: rtl/aes256_block_fifo.sv
// Block FIFO: storage, wrap-around pointers and occupancy level.
// Ports: clk, rst, push, pop, flush, din, dout (head), level, full, empty.
module aes256_block_fifo
   import aes256_unload_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  aes_block_t                   din,
   output aes_block_t                   dout,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         full,
   output logic                         empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);

   aes_block_t     mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;

   // DEPTH is a power of two, so pointers wrap naturally
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = (level == LW'(DEPTH));
   assign empty = (level == '0);

endmodule

// File: rtl/aes256_unload_buffer.sv
// Output stage of the AES-256 core: buffers ciphertext blocks and
// serialises them MSB word first over a req/ready handshake.
// Ports: clk, rst (sync, active-high), pi_enc_done, pi_data, pi_flush,
//   pi_next_val_req, po_next_val_ready, po_data, po_block_done,
//   po_level, po_empty, po_full, po_overflow, po_underflow.
// Macro AES256_UNLOAD_STATS_EN adds po_blocks_sent and po_drops.
module aes256_unload_buffer
   import aes256_unload_pkg::*;
#(
   parameter int OUT_W = 8,
   parameter int DEPTH = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        pi_enc_done,
   input  logic [127:0]                pi_data,
   input  logic                        pi_flush,
   input  logic                        pi_next_val_req,
   output logic                        po_next_val_ready,
   output logic [OUT_W-1:0]            po_data,
   output logic                        po_block_done,
   output logic [$clog2(DEPTH+1)-1:0]  po_level,
   output logic                        po_empty,
   output logic                        po_full,
   output logic                        po_overflow,
   output logic                        po_underflow
`ifdef AES256_UNLOAD_STATS_EN
  ,output logic [31:0]                 po_blocks_sent
  ,output logic [15:0]                 po_drops
`endif
);

   localparam int WPB = words_per_block(OUT_W);
   localparam int CW  = (WPB > 1) ? $clog2(WPB) : 1;
   localparam int LW  = $clog2(DEPTH + 1);

   if (OUT_W != 8 && OUT_W != 16 && OUT_W != 32 &&
       OUT_W != 64 && OUT_W != 128) begin : g_bad_w
      $error("OUT_W must be 8, 16, 32, 64 or 128");
   end

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_d
      $error("DEPTH must be a power of two >= 2");
   end

   unload_state_t     state;
   logic [CW-1:0]     cnt;
   aes_block_t        head;
   aes_block_t        shifted;
   logic [OUT_W-1:0]  word;
   logic [LW-1:0]     level;
   logic              fifo_full;
   logic              fifo_empty;
   logic              has_data;
   logic              last_word;
   logic              req_ok;
   logic              pop;
   logic              push;
   logic              ovf;
   logic              udf;

   assign has_data  = (state == ST_ACTIVE);
   assign last_word = (cnt == CW'(WPB - 1));
   assign req_ok    = pi_next_val_req & ~pi_flush & has_data;
   assign pop       = req_ok & last_word;
   // a same-cycle pop frees the slot a full FIFO needs
   assign push      = pi_enc_done & ~pi_flush & (~fifo_full | pop);
   assign ovf       = pi_enc_done & ~pi_flush & fifo_full & ~pop;
   assign udf       = pi_next_val_req & ~pi_flush & ~has_data;

   assign shifted = head << (32'(cnt) * OUT_W);
   assign word    = shifted[AES_BLOCK_W-1 -: OUT_W];

   aes256_block_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (pi_flush),
      .din   (pi_data),
      .dout  (head),
      .level (level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= ST_EMPTY;
         cnt               <= '0;
         po_next_val_ready <= 1'b0;
         po_data           <= '0;
         po_block_done     <= 1'b0;
         po_overflow       <= 1'b0;
         po_underflow      <= 1'b0;
      end else begin
         po_next_val_ready <= req_ok;
         po_block_done     <= pop;
         po_overflow       <= ovf;
         po_underflow      <= udf;
         if (req_ok) po_data <= word;

         if (pi_flush)
            cnt <= '0;
         else if (req_ok)
            cnt <= last_word ? '0 : cnt + 1'b1;

         if (pi_flush)
            state <= ST_EMPTY;
         else if (push)
            state <= ST_ACTIVE;
         else if (pop && level == LW'(1))
            state <= ST_EMPTY;
      end
   end

   assign po_level = level;
   assign po_empty = fifo_empty;
   assign po_full  = fifo_full;

`ifdef AES256_UNLOAD_STATS_EN
   // updated alongside the flag registers so counts track the pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         po_blocks_sent <= '0;
         po_drops       <= '0;
      end else begin
         if (pop) po_blocks_sent <= po_blocks_sent + 1'b1;
         if (ovf && po_drops != 16'hFFFF)
            po_drops <= po_drops + 1'b1;
      end
   end
`endif

endmodule
